// File: rtl/parking_keypad_encoder.sv
// Keypad front end: turns decimal key presses into an 8-bit password attempt
// with a one-cycle try strobe and a post-strobe hold-off. Optional COLLECT
// inactivity timeout is enabled by defining KEYPAD_TIMEOUT_EN.
module parking_keypad_encoder #(
  parameter int HOLDOFF_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [7:0] psswrd_atmpt,
  output logic       try_psswrd,
  output logic       entry_busy,
  output logic [1:0] digit_cnt,
  output logic       entry_err,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

  if (HOLDOFF_CYCLES < 1) begin : g_bad_holdoff
    $error("HOLDOFF_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]    state, state_d;
  logic          key_q;
  logic [9:0]    acc, acc_d, acc_mac;
  logic [1:0]    cnt_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic [7:0]    atmpt_d;
  logic          try_d, err_d;
  logic          accept, is_digit, is_clear, is_enter, timeout_hit;

  assign accept   = key_valid & ~key_q;
  assign is_digit = accept && (key_code <= 4'd9);
  assign is_clear = accept && (key_code == 4'hA);
  assign is_enter = accept && (key_code == 4'hB);
  // Only evaluated with fewer than 3 digits held, so acc <= 99 and no overflow.
  assign acc_mac  = (acc << 3) + (acc << 1) + {6'd0, key_code};

`ifdef KEYPAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              idle_cnt <= '0;
    else if (state != ST_COLLECT || accept) idle_cnt <= '0;
    else                                  idle_cnt <= idle_cnt + 1'b1;
  end

  assign timeout_hit = (state == ST_COLLECT) && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = digit_cnt;
    hold_d  = hold_cnt;
    atmpt_d = psswrd_atmpt;
    try_d   = 1'b0;
    err_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_digit) begin
          acc_d   = {6'd0, key_code};
          cnt_d   = 2'd1;
          state_d = ST_COLLECT;
        end else if (is_enter) begin
          err_d = 1'b1;
        end
      end
      ST_COLLECT: begin
        // A key edge wins over a simultaneous timeout expiry.
        if (is_digit) begin
          if (digit_cnt != 2'd3) begin
            acc_d = acc_mac;
            cnt_d = digit_cnt + 2'd1;
          end
        end else if (is_clear) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (is_enter) begin
          acc_d = '0;
          cnt_d = '0;
          if (acc <= 10'd255) begin
            atmpt_d = acc[7:0];
            try_d   = 1'b1;
            hold_d  = '0;
            state_d = ST_HOLD;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (!accept && timeout_hit) begin
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_d = ST_IDLE;
        else                       hold_d  = hold_cnt + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // key_q resets high so a key held through reset never produces an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      key_q        <= 1'b1;
      acc          <= '0;
      digit_cnt    <= '0;
      hold_cnt     <= '0;
      psswrd_atmpt <= '0;
      try_psswrd   <= 1'b0;
      entry_err    <= 1'b0;
    end else begin
      state        <= state_d;
      key_q        <= key_valid;
      acc          <= acc_d;
      digit_cnt    <= cnt_d;
      hold_cnt     <= hold_d;
      psswrd_atmpt <= atmpt_d;
      try_psswrd   <= try_d;
      entry_err    <= err_d;
    end
  end

  assign entry_busy = (state == ST_COLLECT);
  assign state_dbg  = state;

endmodule
